// File: rtl/tmr_recovery_controller.sv
// Recovery sequencer for one faulty core of the TMR MiV system: isolate, reset, resync, verify.
// Optional software trigger (sw_req/sw_core_sel) is enabled by defining TMR_RECOVERY_SW_TRIGGER_EN.
module tmr_recovery_controller #(
    parameter int MASK_CYCLES    = 8,
    parameter int RESET_CYCLES   = 32,
    parameter int RESYNC_TIMEOUT = 4096,
    parameter int VERIFY_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int TIMER_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] core_faulty,
    input  logic [2:0] fault_now,
    input  logic [2:0] resync_done,
`ifdef TMR_RECOVERY_SW_TRIGGER_EN
    input  logic       sw_req,
    input  logic [1:0] sw_core_sel,
`endif
    output logic [2:0] vote_mask,
    output logic [2:0] core_rst_n,
    output logic       mon_clear,
    output logic       busy,
    output logic       tmr_fatal,
    output logic [1:0] active_core,
    output logic [2:0] state,
    output logic [7:0] recovery_cnt
);

    // state      | meaning
    // IDLE       | waiting for a single-core fault
    // ISOLATE    | core masked out of the voters before reset
    // RESET_HOLD | core reset asserted
    // RESYNC     | core released, waiting for resync_done
    // VERIFY     | core back in the vote, must stay fault-free
    // FATAL      | TMR lost; sticky until rst_n
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISOLATE    = 3'd1,
        S_RESET_HOLD = 3'd2,
        S_RESYNC     = 3'd3,
        S_VERIFY     = 3'd4,
        S_FATAL      = 3'd7
    } state_t;

    state_t             state_q, state_nx;
    logic [TIMER_W-1:0] timer;
    logic [7:0]         retries_q, retries_nx;
    logic [1:0]         active_nx;
    logic [7:0]         cnt_nx;
    logic [2:0]         active_oh, nx_oh, flags;
    logic [1:0]         pop;
    logic               fail, other_fault, own_fault, ignore_win;

    assign state       = state_q;
    assign active_oh   = 3'b001 << active_core;
    assign nx_oh       = 3'b001 << active_nx;
    assign flags       = core_faulty | fault_now;
    assign other_fault = |(flags & ~active_oh);
    assign own_fault   = |(flags & active_oh);
    assign pop         = {1'b0, core_faulty[0]} + {1'b0, core_faulty[1]} + {1'b0, core_faulty[2]};
    // The monitor needs two cycles to honour mon_clear, so its flags are stale until then.
    assign ignore_win  = (timer < TIMER_W'(2));

    always_comb begin
        state_nx   = state_q;
        active_nx  = active_core;
        retries_nx = retries_q;
        cnt_nx     = recovery_cnt;
        fail       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop >= 2'd2) begin
                    state_nx = S_FATAL;
                end else if (pop == 2'd1) begin
                    state_nx   = S_ISOLATE;
                    active_nx  = core_faulty[2] ? 2'd2 : (core_faulty[1] ? 2'd1 : 2'd0);
                    retries_nx = '0;
                end
`ifdef TMR_RECOVERY_SW_TRIGGER_EN
                else if (sw_req && sw_core_sel != 2'd3) begin
                    state_nx   = S_ISOLATE;
                    active_nx  = sw_core_sel;
                    retries_nx = '0;
                end
`endif
            end
            S_ISOLATE: begin
                if (other_fault)                                  state_nx = S_FATAL;
                else if (timer == TIMER_W'(MASK_CYCLES - 1))      state_nx = S_RESET_HOLD;
            end
            S_RESET_HOLD: begin
                if (other_fault)                                  state_nx = S_FATAL;
                else if (timer == TIMER_W'(RESET_CYCLES - 1))     state_nx = S_RESYNC;
            end
            S_RESYNC: begin
                if (other_fault)                                  state_nx = S_FATAL;
                else if (|(resync_done & active_oh))              state_nx = S_VERIFY;
                else if (timer == TIMER_W'(RESYNC_TIMEOUT - 1))   fail     = 1'b1;
            end
            S_VERIFY: begin
                if (!ignore_win && other_fault) begin
                    state_nx = S_FATAL;
                end else if (!ignore_win && own_fault) begin
                    fail = 1'b1;
                end else if (timer == TIMER_W'(VERIFY_CYCLES - 1)) begin
                    state_nx  = S_IDLE;
                    active_nx = 2'd3;
                    cnt_nx    = (recovery_cnt == 8'hFF) ? 8'hFF : recovery_cnt + 8'd1;
                end
            end
            S_FATAL:  state_nx = S_FATAL;
            default:  state_nx = S_IDLE;
        endcase
        if (fail) begin
            retries_nx = retries_q + 8'd1;
            state_nx   = (retries_nx < 8'(MAX_RETRIES)) ? S_ISOLATE : S_FATAL;
        end
        if (state_nx == S_FATAL) active_nx = 2'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            timer        <= '0;
            retries_q    <= '0;
            active_core  <= 2'd3;
            recovery_cnt <= '0;
            vote_mask    <= 3'b000;
            core_rst_n   <= 3'b111;
            mon_clear    <= 1'b0;
            busy         <= 1'b0;
            tmr_fatal    <= 1'b0;
        end else begin
            state_q      <= state_nx;
            retries_q    <= retries_nx;
            active_core  <= active_nx;
            recovery_cnt <= cnt_nx;
            if (state_nx != state_q || state_nx == S_IDLE || state_nx == S_FATAL)
                timer <= '0;
            else
                timer <= timer + 1'b1;
            // Outputs are decoded from the next state so they change with the state register.
            vote_mask  <= (state_nx == S_ISOLATE || state_nx == S_RESET_HOLD || state_nx == S_RESYNC)
                          ? nx_oh : 3'b000;
            core_rst_n <= (state_nx == S_RESET_HOLD) ? ~nx_oh : 3'b111;
            mon_clear  <= (state_nx == S_VERIFY) && (state_q != S_VERIFY);
            busy       <= (state_nx != S_IDLE) && (state_nx != S_FATAL);
            tmr_fatal  <= (state_nx == S_FATAL);
        end
    end

endmodule

// File: tb/tb_tmr_recovery_controller.sv
// Self-checking bench for tmr_recovery_controller: scenario-level model of phase durations and outcome.
module tb_tmr_recovery_controller;
    localparam int MASK = 8, RST = 32, TO = 4096, VER = 1024, MAXR = 3;
    localparam logic [2:0] S_IDLE = 3'd0, S_ISO = 3'd1, S_RH = 3'd2, S_RSY = 3'd3, S_VER = 3'd4, S_FAT = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] core_faulty, fault_now, resync_done;
    logic [2:0] vote_mask, core_rst_n, state;
    logic       mon_clear, busy, tmr_fatal;
    logic [1:0] active_core;
    logic [7:0] recovery_cnt;
`ifdef TMR_RECOVERY_SW_TRIGGER_EN
    logic       sw_req;
    logic [1:0] sw_core_sel;
`endif

    int tests_run = 0, tests_failed = 0;

    // scenario description: per attempt resync delay (0 = never), verify fault kind/cycle
    int         sc_core, sc_early, sc_use_cf;
    logic [2:0] sc_other;
    int         sc_resync[3], sc_vk[3], sc_vc[3];
    int         e_iso, e_hold, e_rsy, e_ver, e_mclr, e_succ;
    logic [2:0] e_final;

    tmr_recovery_controller dut (
        .clk(clk), .rst_n(rst_n),
        .core_faulty(core_faulty), .fault_now(fault_now), .resync_done(resync_done),
`ifdef TMR_RECOVERY_SW_TRIGGER_EN
        .sw_req(sw_req), .sw_core_sel(sw_core_sel),
`endif
        .vote_mask(vote_mask), .core_rst_n(core_rst_n), .mon_clear(mon_clear), .busy(busy),
        .tmr_fatal(tmr_fatal), .active_core(active_core), .state(state), .recovery_cnt(recovery_cnt)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0; core_faulty = '0; fault_now = '0; resync_done = '0;
`ifdef TMR_RECOVERY_SW_TRIGGER_EN
        sw_req = 1'b0; sw_core_sel = 2'd3;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Expected phase durations and outcome from the recovery rules.
    task automatic model_run();
        int retries = 0;
        bit done = 0;
        e_iso = 0; e_hold = 0; e_rsy = 0; e_ver = 0; e_mclr = 0; e_succ = 0; e_final = S_FAT;
        for (int a = 0; a < 3 && !done; a++) begin
            e_iso += MASK; e_hold += RST;
            if (sc_resync[a] == 0) begin
                e_rsy += TO; retries++;
                if (retries >= MAXR) begin e_final = S_FAT; done = 1; end
            end else begin
                e_rsy += sc_resync[a]; e_mclr++;
                if (sc_vk[a] != 0 && sc_vc[a] >= 2 && sc_vc[a] < VER) begin
                    e_ver += sc_vc[a] + 1;
                    if (sc_vk[a] == 2) begin e_final = S_FAT; done = 1; end
                    else begin
                        retries++;
                        if (retries >= MAXR) begin e_final = S_FAT; done = 1; end
                    end
                end else begin
                    e_ver += VER; e_final = S_IDLE; e_succ = 1; done = 1;
                end
            end
        end
    endtask

    task automatic run_scenario(input string name);
        logic [2:0] oh, s, prev;
        logic [7:0] cnt0, cnt_exp;
        int att, rs_k, v_k, n_iso, n_rh, n_rsy, n_ver, n_mclr, n_low, n_bad;
        bit done, entering;
        oh = 3'b001 << sc_core;
        model_run();
        cnt0 = recovery_cnt;
        cnt_exp = (cnt0 == 8'hFF) ? 8'hFF : cnt0 + 8'(e_succ);
        n_iso = 0; n_rh = 0; n_rsy = 0; n_ver = 0; n_mclr = 0; n_low = 0; n_bad = 0;
        att = -1; rs_k = 0; v_k = 0; prev = S_IDLE; done = 0; s = state;
        core_faulty = oh;
        @(negedge clk);
        core_faulty = '0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            s = state;
            if (s == S_IDLE || s == S_FAT) done = 1;
            else begin
                entering = (s != prev);
                if (entering && s == S_ISO) att++;
                if (att < 0) att = 0;
                if (att > 2) att = 2;
                if (entering) begin rs_k = 0; v_k = 0; end
                if (s == S_ISO) n_iso++;
                else if (s == S_RH) n_rh++;
                else if (s == S_RSY) n_rsy++;
                else if (s == S_VER) n_ver++;
                else n_bad++;
                if (mon_clear !== (s == S_VER && entering)) n_bad++;
                if (vote_mask !== ((s == S_VER) ? 3'b000 : oh)) n_bad++;
                if (busy !== 1'b1 || tmr_fatal !== 1'b0) n_bad++;
                if (active_core !== 2'(sc_core)) n_bad++;
                n_mclr += int'(mon_clear);
                if (core_rst_n === ~oh) n_low++;
                resync_done = '0; fault_now = '0; core_faulty = '0;
                if (s == S_RSY) begin
                    rs_k++;
                    if (sc_resync[att] != 0 && rs_k == sc_resync[att]) resync_done = oh;
                end
                if (s == S_VER) begin
                    v_k++;
                    if (sc_early >= 0 && v_k == sc_early + 1) fault_now = 3'b111;
                    if (sc_vk[att] != 0 && v_k == sc_vc[att] + 1) begin
                        if (sc_vk[att] == 2) fault_now = sc_other;
                        else if (sc_use_cf != 0) core_faulty = oh;
                        else fault_now = oh;
                    end
                end
                prev = s;
                @(negedge clk);
            end
        end
        resync_done = '0; fault_now = '0; core_faulty = '0;
        tests_run++; if (s !== e_final) begin tests_failed++;
            $display("FAIL %s final_state: got %0d expected %0d", name, s, e_final); end
        tests_run++; if (n_iso != e_iso) begin tests_failed++;
            $display("FAIL %s isolate_cycles: got %0d expected %0d", name, n_iso, e_iso); end
        tests_run++; if (n_rh != e_hold || n_low != e_hold) begin tests_failed++;
            $display("FAIL %s reset_hold_cycles: got %0d/%0d low expected %0d", name, n_rh, n_low, e_hold); end
        tests_run++; if (n_rsy != e_rsy) begin tests_failed++;
            $display("FAIL %s resync_cycles: got %0d expected %0d", name, n_rsy, e_rsy); end
        tests_run++; if (n_ver != e_ver) begin tests_failed++;
            $display("FAIL %s verify_cycles: got %0d expected %0d", name, n_ver, e_ver); end
        tests_run++; if (n_mclr != e_mclr) begin tests_failed++;
            $display("FAIL %s mon_clear_pulses: got %0d expected %0d", name, n_mclr, e_mclr); end
        tests_run++; if (n_bad != 0) begin tests_failed++;
            $display("FAIL %s per_cycle_outputs: got %0d bad cycles expected 0", name, n_bad); end
        tests_run++; if (recovery_cnt !== cnt_exp) begin tests_failed++;
            $display("FAIL %s recovery_cnt: got %0d expected %0d", name, recovery_cnt, cnt_exp); end
        tests_run++;
        if (tmr_fatal !== (e_final == S_FAT) || vote_mask !== 3'b000 || core_rst_n !== 3'b111 || busy !== 1'b0)
        begin tests_failed++;
            $display("FAIL %s end_outputs: got fatal=%b mask=%b rst=%b busy=%b expected fatal=%b mask=000 rst=111 busy=0",
                     name, tmr_fatal, vote_mask, core_rst_n, busy, e_final == S_FAT); end
        if (e_succ == 1) begin
            tests_run++; if (active_core !== 2'd3) begin tests_failed++;
                $display("FAIL %s active_core_after: got %0d expected 3", name, active_core); end
        end
    endtask

    task automatic clear_scenario(input int core, input int d);
        sc_core = core; sc_early = -1; sc_use_cf = 0;
        sc_other = 3'b001 << ((core + 1) % 3);
        for (int a = 0; a < 3; a++) begin sc_resync[a] = d; sc_vk[a] = 0; sc_vc[a] = 0; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; core_faulty = '0; fault_now = '0; resync_done = '0;
`ifdef TMR_RECOVERY_SW_TRIGGER_EN
        sw_req = 1'b0; sw_core_sel = 2'd3;
`endif
        #12;
        tests_run++;
        if ({vote_mask, core_rst_n, mon_clear, busy, tmr_fatal, active_core, state, recovery_cnt} !==
            {3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 2'd3, S_IDLE, 8'd0}) begin
            tests_failed++;
            $display("FAIL reset_values: got mask=%b rst=%b mclr=%b busy=%b fatal=%b act=%0d st=%0d cnt=%0d",
                     vote_mask, core_rst_n, mon_clear, busy, tmr_fatal, active_core, state, recovery_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++; if (state !== S_IDLE || busy !== 1'b0) begin tests_failed++;
            $display("FAIL idle_quiet: got state=%0d busy=%b expected 0/0", state, busy); end
    endtask

    task automatic test_basic_recovery();
        apply_reset();
        clear_scenario(2, 5);
        run_scenario("basic_A");
    endtask

    task automatic test_resync_timeout();
        apply_reset();
        clear_scenario(1, 0);
        run_scenario("timeout_B");
    endtask

    task automatic test_multi_fault();
        logic [2:0] pats [4];
        logic [2:0] p;
        pats[0] = 3'b011; pats[1] = 3'b101; pats[2] = 3'b110; pats[3] = 3'b111;
        apply_reset();
        p = pats[$urandom_range(0, 3)];
        core_faulty = p;
        @(negedge clk);
        core_faulty = '0;
        tests_run++;
        if (state !== S_FAT || tmr_fatal !== 1'b1 || core_rst_n !== 3'b111 || vote_mask !== 3'b000 || busy !== 1'b0)
        begin tests_failed++;
            $display("FAIL multi_fault %b: got st=%0d fatal=%b rst=%b mask=%b busy=%b expected 7/1/111/000/0",
                     p, state, tmr_fatal, core_rst_n, vote_mask, busy); end
        repeat (6) @(negedge clk);
        tests_run++; if (state !== S_FAT || tmr_fatal !== 1'b1) begin tests_failed++;
            $display("FAIL fatal_sticky: got st=%0d fatal=%b expected 7/1", state, tmr_fatal); end
    endtask

    task automatic test_verify_other_fault();
        apply_reset();
        clear_scenario(0, 3);
        sc_other = 3'b100; sc_vk[0] = 2; sc_vc[0] = 10;
        run_scenario("verify_other_C");
    endtask

    task automatic test_verify_retry();
        apply_reset();
        clear_scenario(2, 7);
        sc_early = 1; sc_vk[0] = 1; sc_vc[0] = 50; sc_resync[1] = int'($urandom_range(1, 40));
        run_scenario("verify_retry_A");
        clear_scenario(int'($urandom_range(0, 2)), 4);
        sc_early = 0; sc_vk[0] = 1; sc_vc[0] = 2; sc_use_cf = 1;
        sc_vk[1] = 1; sc_vc[1] = 1;
        run_scenario("verify_window_edge");
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            apply_reset();
            clear_scenario(int'($urandom_range(0, 2)), 1);
            sc_other = 3'b001 << ((sc_core + 1 + int'($urandom_range(0, 1))) % 3);
            sc_early = int'($urandom_range(0, 2)) - 1;
            sc_use_cf = int'($urandom_range(0, 1));
            for (int a = 0; a < 3; a++) begin
                sc_resync[a] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60));
                sc_vk[a] = int'($urandom_range(0, 3)) % 3;
                case ($urandom_range(0, 3))
                    0: sc_vc[a] = int'($urandom_range(0, 3));
                    1: sc_vc[a] = VER - 1;
                    default: sc_vc[a] = int'($urandom_range(2, VER - 1));
                endcase
            end
            run_scenario($sformatf("random_%0d", n));
        end
    endtask

    task automatic test_side_fault();
        logic [2:0] oh, oth, tgt;
        int c, w;
        apply_reset();
        c = int'($urandom_range(0, 2));
        oh = 3'b001 << c;
        oth = 3'b001 << ((c + 1 + int'($urandom_range(0, 1))) % 3);
        tgt = 3'(1 + $urandom_range(0, 2));
        core_faulty = oh; @(negedge clk); core_faulty = '0;
        fault_now = oh; @(negedge clk); fault_now = '0;
        tests_run++; if (state !== S_ISO) begin tests_failed++;
            $display("FAIL own_fault_in_isolate: got st=%0d expected 1", state); end
        w = 0;
        while (state !== tgt && w < 200) begin
            resync_done = (state === S_RSY) ? oh : 3'b000;
            if (tgt == S_RSY) resync_done = '0;
            @(negedge clk); w++;
        end
        resync_done = '0;
        if ($urandom_range(0, 1) == 1) core_faulty = oth; else fault_now = oth;
        @(negedge clk);
        core_faulty = '0; fault_now = '0;
        tests_run++; if (state !== S_FAT || core_rst_n !== 3'b111 || vote_mask !== 3'b000) begin tests_failed++;
            $display("FAIL side_fault_in_%0d: got st=%0d rst=%b mask=%b expected 7/111/000",
                     tgt, state, core_rst_n, vote_mask); end
    endtask

    task automatic test_async_reset();
        logic [2:0] oh;
        int c, w;
        apply_reset();
        c = int'($urandom_range(0, 2));
        oh = 3'b001 << c;
        core_faulty = oh; @(negedge clk); core_faulty = '0;
        w = 0;
        while (state !== S_RH && w < 50) begin @(negedge clk); w++; end
        repeat ($urandom_range(0, 20)) @(negedge clk);
        tests_run++; if (core_rst_n !== ~oh) begin tests_failed++;
            $display("FAIL hold_before_reset: got %b expected %b", core_rst_n, ~oh); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (core_rst_n !== 3'b111 || state !== S_IDLE || vote_mask !== 3'b000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got rst=%b st=%0d mask=%b busy=%b expected 111/0/000/0",
                     core_rst_n, state, vote_mask, busy); end
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        clear_scenario(int'($urandom_range(0, 2)), int'($urandom_range(1, 20)));
        run_scenario("b2b_first");
        @(negedge clk);
        clear_scenario(int'($urandom_range(0, 2)), int'($urandom_range(1, 20)));
        run_scenario("b2b_second");
        tests_run++; if (recovery_cnt !== 8'd2) begin tests_failed++;
            $display("FAIL b2b_count: got %0d expected 2", recovery_cnt); end
    endtask

`ifdef TMR_RECOVERY_SW_TRIGGER_EN
    task automatic test_sw_trigger();
        apply_reset();
        sw_req = 1'b1; sw_core_sel = 2'd3; @(negedge clk);
        tests_run++; if (state !== S_IDLE) begin tests_failed++;
            $display("FAIL sw_sel3_ignored: got st=%0d expected 0", state); end
        sw_core_sel = 2'd1; @(negedge clk); sw_req = 1'b0;
        tests_run++; if (state !== S_ISO || active_core !== 2'd1 || vote_mask !== 3'b010) begin tests_failed++;
            $display("FAIL sw_trigger_B: got st=%0d act=%0d mask=%b expected 1/1/010", state, active_core, vote_mask); end
        apply_reset();
        sw_req = 1'b1; sw_core_sel = 2'd1; core_faulty = 3'b100; @(negedge clk);
        sw_req = 1'b0; core_faulty = '0;
        tests_run++; if (active_core !== 2'd2) begin tests_failed++;
            $display("FAIL auto_wins: got act=%0d expected 2", active_core); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_recovery();
        test_resync_timeout();
        test_multi_fault();
        test_verify_other_fault();
        test_verify_retry();
        test_side_fault();
        test_async_reset();
        test_back_to_back();
        test_random();
`ifdef TMR_RECOVERY_SW_TRIGGER_EN
        test_sw_trigger();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
